alu_sched: RTL and testbench

Two-requester scheduler and flag-register owner for the 16-bit combinational ALU. It accepts operations from two independent clients, such as the decode/execute path and a microcode/loop unit, over valid/ready handshakes. It arbitrates round-robin, drives the shared ALU for one cycle per operation and holds the processor status flags (PSR) that feed the ALU carry-in. It returns the result and the new flags to the winning requester over a single response channel.

---
 rtl/alu_sched.sv | 207 ++++++++++++++++++++
 tb/tb_alu_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// Two-requester round-robin scheduler in front of the shared 16-bit ALU.
// Owns the processor status flags (psr) and returns results over one response channel.
module alu_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_opcode,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_opcode,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [15:0] resp_data,
    output logic [7:0]  resp_flags,
    output logic        resp_err,
    output logic [15:0] alu_r1,
    output logic [15:0] alu_r2,
    output logic [7:0]  alu_opcode,
    output logic [7:0]  alu_flags_in,
    input  logic [15:0] alu_rout,
    input  logic [7:0]  alu_flags_out,
    output logic [7:0]  psr,
    input  logic        psr_wr_en,
    input  logic [7:0]  psr_wr_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r;
    logic        last_r;
    logic        id_r;
    logic        legal_r;
    logic        resp_valid_r;
    logic        resp_id_r;
    logic [15:0] resp_data_r;
    logic [7:0]  resp_flags_r;
    logic        resp_err_r;
    logic [15:0] alu_r1_r;
    logic [15:0] alu_r2_r;
    logic [7:0]  alu_opcode_r;
    logic [7:0]  psr_r;

    logic        gnt0_s;
    logic        gnt1_s;
    logic        accept_s;
    logic [7:0]  sel_op_s;
    logic [15:0] sel_a_s;
    logic [15:0] sel_b_s;
    logic        sel_legal_s;

    function automatic logic is_legal(input logic [7:0] op);
        case (op)
            8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
            8'h08, 8'h09, 8'h0B, 8'h0C, 8'h0F, 8'h84: is_legal = 1'b1;
            default:                                   is_legal = 1'b0;
        endcase
    endfunction

    // Round-robin grant: on a tie the requester not served last wins.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (state_r == IDLE) begin
            if (req0_valid && req1_valid) begin
                if (last_r) begin
                    gnt0_s = 1'b1;
                end else begin
                    gnt1_s = 1'b1;
                end
            end else begin
                gnt0_s = req0_valid;
                gnt1_s = req1_valid;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_op_s = 8'h00;
        sel_a_s  = 16'h0000;
        sel_b_s  = 16'h0000;
        if (gnt1_s) begin
            sel_op_s = req1_opcode;
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
        end else begin
            sel_op_s = req0_opcode;
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
        end
    end

    assign accept_s    = gnt0_s | gnt1_s;
    assign sel_legal_s = is_legal(sel_op_s);

    // Scheduler FSM; ALU drive is loaded at accept so it is valid for the whole EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_r       <= 1'b1;
            id_r         <= 1'b0;
            legal_r      <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_id_r    <= 1'b0;
            resp_data_r  <= 16'h0000;
            resp_flags_r <= 8'h00;
            resp_err_r   <= 1'b0;
            alu_r1_r     <= 16'h0000;
            alu_r2_r     <= 16'h0000;
            alu_opcode_r <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        id_r    <= gnt1_s;
                        legal_r <= sel_legal_s;
                        if (sel_legal_s) begin
                            alu_opcode_r <= sel_op_s;
                            alu_r1_r     <= sel_a_s;
                            alu_r2_r     <= sel_b_s;
                        end else begin
                            alu_opcode_r <= 8'h00;
                            alu_r1_r     <= 16'h0000;
                            alu_r2_r     <= 16'h0000;
                        end
                        state_r <= EXEC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                EXEC: begin
                    resp_valid_r <= 1'b1;
                    resp_id_r    <= id_r;
                    if (legal_r) begin
                        resp_data_r  <= alu_rout;
                        resp_flags_r <= alu_flags_out;
                        resp_err_r   <= 1'b0;
                    end else begin
                        resp_data_r  <= 16'h0000;
                        resp_flags_r <= 8'h00;
                        resp_err_r   <= 1'b1;
                    end
                    alu_opcode_r <= 8'h00;
                    alu_r1_r     <= 16'h0000;
                    alu_r2_r     <= 16'h0000;
                    state_r      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        last_r       <= resp_id_r;
                        state_r      <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    resp_valid_r <= 1'b0;
                    alu_opcode_r <= 8'h00;
                    alu_r1_r     <= 16'h0000;
                    alu_r2_r     <= 16'h0000;
                end
            endcase
        end
    end

    // Flag register: a legal ALU capture takes priority over a software write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psr_r <= 8'h00;
        end else if ((state_r == EXEC) && legal_r) begin
            psr_r <= alu_flags_out;
        end else if (psr_wr_en) begin
            psr_r <= psr_wr_data;
        end else begin
            psr_r <= psr_r;
        end
    end

    assign req0_ready   = gnt0_s;
    assign req1_ready   = gnt1_s;
    assign resp_valid   = resp_valid_r;
    assign resp_id      = resp_id_r;
    assign resp_data    = resp_data_r;
    assign resp_flags   = resp_flags_r;
    assign resp_err     = resp_err_r;
    assign alu_r1       = alu_r1_r;
    assign alu_r2       = alu_r2_r;
    assign alu_opcode   = alu_opcode_r;
    assign alu_flags_in = psr_r;
    assign psr          = psr_r;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched with a small ALU stub covering the opcodes exercised.
module tb_alu_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_opcode = 8'h00, req1_opcode = 8'h00;
    logic [15:0] req0_a = 16'h0000, req0_b = 16'h0000, req1_a = 16'h0000, req1_b = 16'h0000;
    logic        resp_valid, resp_ready = 1'b0, resp_id, resp_err;
    logic [15:0] resp_data, alu_r1, alu_r2, alu_rout;
    logic [7:0]  resp_flags, alu_opcode, alu_flags_in, alu_flags_out, psr;
    logic        psr_wr_en = 1'b0;
    logic [7:0]  psr_wr_data = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    alu_sched dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_flags(resp_flags), .resp_err(resp_err),
        .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_opcode(alu_opcode),
        .alu_flags_in(alu_flags_in), .alu_rout(alu_rout), .alu_flags_out(alu_flags_out),
        .psr(psr), .psr_wr_en(psr_wr_en), .psr_wr_data(psr_wr_data)
    );

    always #5 clk = ~clk;

    // ALU stub: and/or/add/addc/cmp; anything else returns a poison pattern.
    logic [16:0] sum_s;
    always_comb begin
        sum_s         = 17'h00000;
        alu_rout      = 16'hDEAD;
        alu_flags_out = 8'hFF;
        case (alu_opcode)
            8'h01: begin alu_rout = alu_r1 & alu_r2; alu_flags_out = {1'b0, alu_rout == 16'h0000, 6'b0}; end
            8'h02: begin alu_rout = alu_r1 | alu_r2; alu_flags_out = {1'b0, alu_rout == 16'h0000, 6'b0}; end
            8'h05, 8'h07: begin
                sum_s = {1'b0, alu_r1} + {1'b0, alu_r2} + ((alu_opcode == 8'h07) ? {16'h0000, alu_flags_in[0]} : 17'h00000);
                alu_rout = sum_s[15:0];
                alu_flags_out = {1'b0, sum_s[15:0] == 16'h0000,
                                 (alu_r1[15] == alu_r2[15]) && (sum_s[15] != alu_r1[15]),
                                 4'b0000, sum_s[16]};
            end
            8'h0B: begin
                alu_rout = alu_r1 - alu_r2;
                alu_flags_out = {1'b0, alu_r1 == alu_r2, 3'b000, alu_r1 < alu_r2, 2'b00};
            end
            default: begin alu_rout = 16'hDEAD; alu_flags_out = 8'hFF; end
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_req0(input logic v, input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        req0_valid = v; req0_opcode = op; req0_a = a; req0_b = b;
    endtask

    task automatic set_req1(input logic v, input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        req1_valid = v; req1_opcode = op; req1_a = a; req1_b = b;
    endtask

    initial begin
        do_reset();
        check_eq("rst_resp_valid", resp_valid, 1'b0);
        check_eq("rst_psr", psr, 8'h00);
        check_eq("rst_alu_op", alu_opcode, 8'h00);
        check_eq("rst_resp_data", resp_data, 16'h0000);

        // add 0x7FFF + 1 from req0
        resp_ready = 1'b1;
        set_req0(1'b1, 8'h05, 16'h7FFF, 16'h0001);
        #1;
        check_eq("add_ready", {req1_ready, req0_ready}, 2'b01);
        tick();
        set_req0(1'b0, 8'h00, 16'h0000, 16'h0000);
        check_eq("add_exec_op", alu_opcode, 8'h05);
        check_eq("add_exec_r1", alu_r1, 16'h7FFF);
        check_eq("add_exec_rv", resp_valid, 1'b0);
        tick();
        check_eq("add_rv", resp_valid, 1'b1);
        check_eq("add_id", resp_id, 1'b0);
        check_eq("add_data", resp_data, 16'h8000);
        check_eq("add_flags", resp_flags, 8'h20);
        check_eq("add_psr", psr, 8'h20);
        check_eq("add_alu_idle", alu_opcode, 8'h00);
        tick();
        check_eq("add_done", resp_valid, 1'b0);

        // continuous contention from a fresh reset: 0,1,0,1
        do_reset();
        resp_ready = 1'b1;
        set_req0(1'b1, 8'h01, 16'h00F0, 16'h0FF0);
        set_req1(1'b1, 8'h02, 16'h000F, 16'h0F00);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("rr_grant%0d", i), {req1_ready, req0_ready}, (i % 2) ? 2'b10 : 2'b01);
            tick();
            check_eq($sformatf("rr_stall%0d", i), {req1_ready, req0_ready}, 2'b00);
            tick();
            check_eq($sformatf("rr_id%0d", i), resp_id, (i % 2) ? 1'b1 : 1'b0);
            check_eq($sformatf("rr_data%0d", i), resp_data, (i % 2) ? 16'h0F0F : 16'h00F0);
            tick();
        end
        set_req0(1'b0, 8'h00, 16'h0000, 16'h0000);
        set_req1(1'b0, 8'h00, 16'h0000, 16'h0000);
        tick();

        // cmp 5,5 with a competing psr write during EXEC
        set_req0(1'b1, 8'h0B, 16'h0005, 16'h0005);
        tick();
        set_req0(1'b0, 8'h00, 16'h0000, 16'h0000);
        psr_wr_en = 1'b1; psr_wr_data = 8'hAA;
        tick();
        psr_wr_en = 1'b0;
        check_eq("cmp_flags", resp_flags, 8'h40);
        check_eq("cmp_psr", psr, 8'h40);
        tick();

        // software psr write then addc sees carry-in
        psr_wr_en = 1'b1; psr_wr_data = 8'h01;
        tick();
        psr_wr_en = 1'b0;
        check_eq("psr_wr", psr, 8'h01);
        set_req0(1'b1, 8'h07, 16'h0003, 16'h0004);
        tick();
        set_req0(1'b0, 8'h00, 16'h0000, 16'h0000);
        check_eq("addc_fin", alu_flags_in, 8'h01);
        tick();
        check_eq("addc_data", resp_data, 16'h0008);
        check_eq("addc_psr", psr, 8'h00);
        tick();

        // illegal opcode from req1 leaves psr alone
        psr_wr_en = 1'b1; psr_wr_data = 8'h04;
        tick();
        psr_wr_en = 1'b0;
        set_req1(1'b1, 8'hFF, 16'h1234, 16'h5678);
        #1;
        check_eq("ill_ready", {req1_ready, req0_ready}, 2'b10);
        tick();
        set_req1(1'b0, 8'h00, 16'h0000, 16'h0000);
        check_eq("ill_alu_op", alu_opcode, 8'h00);
        tick();
        check_eq("ill_err", resp_err, 1'b1);
        check_eq("ill_id", resp_id, 1'b1);
        check_eq("ill_data", resp_data, 16'h0000);
        check_eq("ill_flags", resp_flags, 8'h00);
        check_eq("ill_psr", psr, 8'h04);
        tick();

        // backpressure hold, then async reset mid-hold
        resp_ready = 1'b0;
        set_req0(1'b1, 8'h05, 16'h7FFF, 16'h0001);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("hold_rv%0d", i), resp_valid, 1'b1);
            check_eq($sformatf("hold_data%0d", i), resp_data, 16'h8000);
            check_eq($sformatf("hold_err%0d", i), resp_err, 1'b0);
            check_eq($sformatf("hold_rdy%0d", i), req0_ready, 1'b0);
            tick();
        end
        check_eq("hold_psr", psr, 8'h20);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_rv", resp_valid, 1'b0);
        check_eq("arst_psr", psr, 8'h00);
        set_req0(1'b0, 8'h00, 16'h0000, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
